muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (rd_data1/rd_data2) plus funct3 and the destination index when the decoder issues an M-extension op.
- Holds the pipeline via busy for the duration of the operation.
- Produces a one-cycle write-back strobe (wb_en/wb_addr/wb_data) that drives the register file write port (wrEn/ws/wr_data) through the write-back mux.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle write-back strobe.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int unsigned CNT_W  = $clog2(XLEN);
    localparam int unsigned PROD_W = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3_q;
    logic                neg_q;
    logic                rem_neg_q;
    logic [XLEN-1:0]     opnd_q;
    logic [PROD_W-1:0]   acc;

    // Accept-side decode: signedness, magnitudes and the one-cycle special cases
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = is_div ? ~funct3[0] : ~funct3[1];
        sign_a      = a_signed & op_a[XLEN-1];
        sign_b      = b_signed & op_b[XLEN-1];
        mag_a       = sign_a ? (~op_a + XLEN'(1)) : op_a;
        mag_b       = sign_b ? (~op_b + XLEN'(1)) : op_b;
        div_zero    = is_div && (op_b == '0);
        div_ovf     = is_div && !funct3[0] &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [PROD_W-1:0] mul_nxt;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [PROD_W-1:0] div_nxt;
    logic [PROD_W-1:0] acc_nxt;
    logic [PROD_W-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result;

    always_comb begin
        mul_sum   = {1'b0, acc[PROD_W-1:XLEN]} +
                    (acc[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_nxt   = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[PROD_W-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_nxt   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_nxt   = f3_q[2] ? div_nxt : mul_nxt;
        prod      = neg_q ? (~acc_nxt + PROD_W'(1)) : acc_nxt;
        quo       = acc_nxt[XLEN-1:0];
        rem       = acc_nxt[PROD_W-1:XLEN];
        result    = '0;
        case (f3_q)
            3'b000:                 result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod[PROD_W-1:XLEN];
            3'b100, 3'b101:         result = neg_q ? (~quo + XLEN'(1)) : quo;
            default:                result = rem_neg_q ? (~rem + XLEN'(1)) : rem;
        endcase
    end

    // Control FSM with registered outputs and operand/accumulator state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f3_q      <= funct3;
                        neg_q     <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        wb_addr   <= rd_in;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        if (div_zero || div_ovf) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wb_en   <= (rd_in != 5'd0);
                            wb_data <= special_res;
                        end else begin
                            state  <= CALC;
                            opnd_q <= is_div ? mag_b : mag_a;
                            acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wb_en   <= (wb_addr != 5'd0);
                        wb_data <= result;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int compared;
    int mismatched;

    logic [31:0] exp_q[$];
    logic [4:0]  addr_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, pop the scoreboard and check write-back
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input int inject_at);
        int n;
        int extra;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        exp_q.push_back(exp);
        addr_q.push_back(rd);
        @(negedge clk);
        start  = 1'b0;
        funct3 = ~f3;
        op_a   = ~a;
        op_b   = ~b;
        rd_in  = ~rd;
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            if (inject_at != 0 && n == inject_at) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op_a   = 32'd11;
                op_b   = 32'd11;
                rd_in  = 5'd3;
            end
            @(negedge clk);
            n++;
            start = 1'b0;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        e_data = exp_q.pop_front();
        e_addr = addr_q.pop_front();
        chk({tag, "_data"}, wb_data, e_data);
        chk({tag, "_addr"}, 32'(wb_addr), 32'(e_addr));
        chk({tag, "_wb_en"}, 32'(wb_en), 32'(e_addr != 5'd0));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, wb_data, e_data);
        if (inject_at != 0) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            chk({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int n;
        int extra;
        clk        = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        funct3     = 3'b000;
        op_a       = '0;
        op_b       = '0;
        rd_in      = '0;
        compared   = 0;
        mismatched = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);

        run_op("mul_7x6",   3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       33, 0);
        run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33, 0);
        run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33, 0);
        run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33, 0);
        run_op("mul_neg",   3'b000, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1, 33, 0);
        run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 33, 0);
        run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 33, 0);
        run_op("divu",      3'b101, 32'd100,      32'd7,        5'd8,  32'd14,       33, 0);
        run_op("remu",      3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        33, 0);
        run_op("div_by0",   3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1,  0);
        run_op("remu_by0",  3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1,  0);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1,  0);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1,  0);
        run_op("mul_x0",    3'b000, 32'd3,        32'd3,        5'd0,  32'd9,        33, 10);

        // Reset in the middle of a DIVU aborts it without a write-back
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        rd_in  = 5'd14;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        extra = 0;
        while (n < 14) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) extra++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wb_en", 32'(wb_en), 32'd0);
        chk("abort_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || wb_en === 1'b1) extra++;
        end
        chk("abort_no_wb", 32'(extra), 32'd0);

        run_op("mul_2x2",   3'b000, 32'd2,        32'd2,        5'd15, 32'd4,        33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
